// File: rtl/audio_pkg.sv
// Shared audio/display definitions: bar geometry, peak-hold counter width and
// the frame-processing state encoding used by the bar smoothing logic.
package audio_pkg;

  localparam int NUM_BARS  = 16;
  localparam int BAR_WIDTH = 18;
  localparam int HOLD_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } bar_state_e;

  function automatic logic state_busy(input bar_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/bar_decay_unit.sv
// Combinational per-bar update: attack/decay smoothing plus peak-hold marker
// with hold countdown, peak clamped so it never sits below the smoothed bar.
module bar_decay_unit
  import audio_pkg::*;
#(
  parameter int BAR_W       = BAR_WIDTH,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  logic [BAR_W-1:0]  in_val,
  input  logic [BAR_W-1:0]  cur,
  input  logic [BAR_W-1:0]  pk,
  input  logic [HOLD_W-1:0] hold,
  output logic [BAR_W-1:0]  cur_next,
  output logic [BAR_W-1:0]  pk_next,
  output logic [HOLD_W-1:0] hold_next
);

  localparam logic [BAR_W-1:0] ZERO = {BAR_W{1'b0}};

  // Proportional decay, but always at least one LSB so tails reach zero.
  function automatic logic [BAR_W-1:0] decay_step(input logic [BAR_W-1:0] v);
    logic [BAR_W-1:0] s;
    s = v >> DECAY_SHIFT;
    return (s == ZERO) ? BAR_W'(1) : s;
  endfunction

  logic [BAR_W-1:0] cur_dec;
  logic [BAR_W-1:0] pk_raw;

  // Smoothed value and peak/hold update for the bar currently selected.
  always_comb begin
    cur_dec   = ZERO;
    pk_raw    = pk;
    hold_next = hold;
    cur_next  = cur;

    if (in_val >= cur) begin
      cur_next = in_val;
    end else begin
      // cur > in_val >= 0, so the step never exceeds cur.
      cur_dec  = cur - decay_step(cur);
      cur_next = (cur_dec > in_val) ? cur_dec : in_val;
    end

    if (in_val >= pk) begin
      pk_raw    = in_val;
      hold_next = HOLD_W'(HOLD_FRAMES);
    end else if (hold != {HOLD_W{1'b0}}) begin
      pk_raw    = pk;
      hold_next = hold - HOLD_W'(1);
    end else begin
      pk_raw    = pk - decay_step(pk);
      hold_next = {HOLD_W{1'b0}};
    end

    pk_next = (pk_raw < cur_next) ? cur_next : pk_raw;
  end

endmodule

// File: rtl/bar_peak_decay.sv
// Spectrum bar smoother: captures a frame of raw bar magnitudes, walks them
// one per cycle through a shared decay unit, then publishes all bars at once.
module bar_peak_decay
  import audio_pkg::*;
#(
  parameter int NBARS       = NUM_BARS,
  parameter int BAR_W       = BAR_WIDTH,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                   clk_25,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NBARS*BAR_W-1:0] bars_in,
  output logic                   busy,
  output logic                   done,
  output logic [NBARS*BAR_W-1:0] bars_out,
  output logic [NBARS*BAR_W-1:0] peaks_out
);

  localparam int IDX_W = (NBARS > 1) ? $clog2(NBARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBARS - 1);

  bar_state_e state;
  bar_state_e state_next;

  logic [IDX_W-1:0]        idx;
  logic [NBARS*BAR_W-1:0]  in_reg;
  logic [NBARS*BAR_W-1:0]  cur_vec;
  logic [NBARS*BAR_W-1:0]  pk_vec;
  logic [NBARS*HOLD_W-1:0] hold_vec;

  logic [NBARS*BAR_W-1:0]  cur_upd;
  logic [NBARS*BAR_W-1:0]  pk_upd;
  logic [NBARS*HOLD_W-1:0] hold_upd;

  logic [BAR_W-1:0]  sel_in;
  logic [BAR_W-1:0]  sel_cur;
  logic [BAR_W-1:0]  sel_pk;
  logic [HOLD_W-1:0] sel_hold;
  logic [BAR_W-1:0]  cur_next;
  logic [BAR_W-1:0]  pk_next;
  logic [HOLD_W-1:0] hold_next;

  assign sel_in   = in_reg[int'(idx)*BAR_W +: BAR_W];
  assign sel_cur  = cur_vec[int'(idx)*BAR_W +: BAR_W];
  assign sel_pk   = pk_vec[int'(idx)*BAR_W +: BAR_W];
  assign sel_hold = hold_vec[int'(idx)*HOLD_W +: HOLD_W];

  bar_decay_unit #(
    .BAR_W      (BAR_W),
    .DECAY_SHIFT(DECAY_SHIFT),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_unit (
    .in_val   (sel_in),
    .cur      (sel_cur),
    .pk       (sel_pk),
    .hold     (sel_hold),
    .cur_next (cur_next),
    .pk_next  (pk_next),
    .hold_next(hold_next)
  );

  // Working vectors with the current bar's new state merged in.
  always_comb begin
    cur_upd  = cur_vec;
    pk_upd   = pk_vec;
    hold_upd = hold_vec;
    cur_upd[int'(idx)*BAR_W +: BAR_W]    = cur_next;
    pk_upd[int'(idx)*BAR_W +: BAR_W]     = pk_next;
    hold_upd[int'(idx)*HOLD_W +: HOLD_W] = hold_next;
  end

  // Frame sequencing: idle, one cycle per bar, one publish cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_PROC;
        else       state_next = ST_IDLE;
      end
      ST_PROC: begin
        if (idx == LAST_IDX) state_next = ST_DONE;
        else                 state_next = ST_PROC;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; busy/done registered from the next state to stay glitch-free.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= state_busy(state_next);
      done  <= (state_next == ST_DONE);
    end
  end

  // Capture, per-bar working state, and atomic publish of the finished frame.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      idx       <= {IDX_W{1'b0}};
      in_reg    <= {(NBARS*BAR_W){1'b0}};
      cur_vec   <= {(NBARS*BAR_W){1'b0}};
      pk_vec    <= {(NBARS*BAR_W){1'b0}};
      hold_vec  <= {(NBARS*HOLD_W){1'b0}};
      bars_out  <= {(NBARS*BAR_W){1'b0}};
      peaks_out <= {(NBARS*BAR_W){1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= {IDX_W{1'b0}};
          if (start) in_reg <= bars_in;
        end
        ST_PROC: begin
          cur_vec  <= cur_upd;
          pk_vec   <= pk_upd;
          hold_vec <= hold_upd;
          if (idx == LAST_IDX) begin
            idx       <= {IDX_W{1'b0}};
            bars_out  <= cur_upd;
            peaks_out <= pk_upd;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: idx <= {IDX_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_bar_peak_decay.sv
// Directed bench for bar_peak_decay: frame-level behavioural model checked every
// cycle, plus hand-computed expectations for latency, decay, hold and reset.
module tb_bar_peak_decay;

  localparam int NB = 16;
  localparam int BW = 18;
  localparam int VW = NB * BW;

  logic          clk_25 = 1'b0;
  logic          rst    = 1'b1;
  logic          start  = 1'b0;
  logic [VW-1:0] bars_in = '0;
  logic          busy;
  logic          done;
  logic [VW-1:0] bars_out;
  logic [VW-1:0] peaks_out;

  bar_peak_decay dut (
    .clk_25   (clk_25),
    .rst      (rst),
    .start    (start),
    .bars_in  (bars_in),
    .busy     (busy),
    .done     (done),
    .bars_out (bars_out),
    .peaks_out(peaks_out)
  );

  always #20 clk_25 = ~clk_25;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int done_cnt = 0;
  bit chk_en   = 0;

  // frame-level model state
  int m_cur[NB];
  int m_pk[NB];
  int m_hold[NB];
  int pend[NB];
  int cycles_left = 0;
  logic [VW-1:0] exp_bars  = '0;
  logic [VW-1:0] exp_peaks = '0;
  bit exp_busy = 0;
  bit exp_done = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bar_of(input logic [VW-1:0] v, input int i);
    return int'(v[i*BW +: BW]);
  endfunction

  function automatic logic [VW-1:0] set_bar(input logic [VW-1:0] v, input int i, input int x);
    logic [VW-1:0] r;
    r = v;
    r[i*BW +: BW] = BW'(x);
    return r;
  endfunction

  function automatic logic [VW-1:0] all_of(input int x);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*BW +: BW] = BW'(x);
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_cur[i] = 0; m_pk[i] = 0; m_hold[i] = 0;
    end
    exp_bars = '0;
    exp_peaks = '0;
    cycles_left = 0;
  endtask

  // whole-frame update applied the moment the frame is published
  task automatic apply_frame();
    int in, c, p, h, nc, np, nh;
    for (int i = 0; i < NB; i++) begin
      in = pend[i]; c = m_cur[i]; p = m_pk[i]; h = m_hold[i];
      nc = (in >= c) ? in : imax(in, c - imax(c / 8, 1));
      if (in >= p) begin
        np = in; nh = 30;
      end else if (h > 0) begin
        np = p; nh = h - 1;
      end else begin
        np = p - imax(p / 8, 1); nh = 0;
      end
      np = imax(np, nc);
      m_cur[i] = nc; m_pk[i] = np; m_hold[i] = nh;
      exp_bars  = set_bar(exp_bars, i, nc);
      exp_peaks = set_bar(exp_peaks, i, np);
    end
  endtask

  // model: a frame occupies 17 cycles after its start; start ignored meanwhile
  initial forever begin
    @(posedge clk_25);
    edge_cnt++;
    if (rst) begin
      model_clear();
    end else if (cycles_left == 0) begin
      if (start) begin
        for (int i = 0; i < NB; i++) pend[i] = bar_of(bars_in, i);
        cycles_left = NB + 1;
      end
    end else begin
      cycles_left--;
      if (cycles_left == 1) apply_frame();
    end
    exp_busy = (cycles_left != 0);
    exp_done = (cycles_left == 1);
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk_25);
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      check("cyc_busy", VW'(busy), VW'(exp_busy));
      check("cyc_done", VW'(done), VW'(exp_done));
      check("cyc_bars", bars_out, exp_bars);
      check("cyc_peaks", peaks_out, exp_peaks);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk_25);
    rst = 1'b1;
    repeat (2) @(negedge clk_25);
    rst = 1'b0;
  endtask

  // start a frame and wait for its done pulse; ends on the done cycle's negedge
  task automatic run_frame(input logic [VW-1:0] data);
    int e0;
    bit got;
    @(negedge clk_25);
    start = 1'b1;
    bars_in = data;
    @(negedge clk_25);
    start = 1'b0;
    e0 = edge_cnt;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk_25);
    end
    check("done_seen", VW'(got), VW'(1));
    check("latency", VW'(edge_cnt - e0), VW'(16));
  endtask

  int exp_decay[3] = '{875, 766, 671};
  int dc;
  int d1;

  initial begin
    repeat (3) @(negedge clk_25);
    chk_en = 1;
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_bars", bars_out, '0);
    check("rst_peaks", peaks_out, '0);
    rst = 1'b0;

    // latency with all bars at 100
    run_frame(all_of(100));
    check("lat_bar0", VW'(bar_of(bars_out, 0)), VW'(100));
    check("lat_bar15", VW'(bar_of(bars_out, 15)), VW'(100));
    check("lat_peak0", VW'(bar_of(peaks_out, 0)), VW'(100));
    check("lat_peak15", VW'(bar_of(peaks_out, 15)), VW'(100));
    @(negedge clk_25);
    check("done_one_cycle", VW'(done), VW'(0));
    check("idle_after_done", VW'(busy), VW'(0));

    // decay: bar0 from 1000, bar1 tail from 7 with minimum step of 1
    do_reset();
    run_frame(set_bar(set_bar(all_of(0), 0, 1000), 1, 7));
    check("dec_bar0_f1", VW'(bar_of(bars_out, 0)), VW'(1000));
    check("dec_bar1_f1", VW'(bar_of(bars_out, 1)), VW'(7));
    for (int k = 0; k < 7; k++) begin
      run_frame(all_of(0));
      if (k < 3) check("dec_bar0", VW'(bar_of(bars_out, 0)), VW'(exp_decay[k]));
      check("dec_tail", VW'(bar_of(bars_out, 1)), VW'(6 - k));
    end

    // peak hold on bar3
    do_reset();
    run_frame(set_bar(all_of(0), 3, 1000));
    check("hold_peak_f0", VW'(bar_of(peaks_out, 3)), VW'(1000));
    for (int k = 1; k <= 31; k++) begin
      run_frame(all_of(0));
      check("hold_peak", VW'(bar_of(peaks_out, 3)), VW'((k <= 30) ? 1000 : 875));
    end

    // start during busy is ignored
    dc = done_cnt;
    @(negedge clk_25);
    start = 1'b1;
    bars_in = all_of(200);
    @(negedge clk_25);
    start = 1'b0;
    repeat (4) @(negedge clk_25);
    start = 1'b1;
    bars_in = all_of(300);
    @(negedge clk_25);
    start = 1'b0;
    bars_in = '0;
    repeat (30) @(negedge clk_25);
    check("busy_start_dones", VW'(done_cnt - dc), VW'(1));
    check("busy_start_bar5", VW'(bar_of(bars_out, 5)), VW'(200));
    check("busy_start_peak5", VW'(bar_of(peaks_out, 5)), VW'(200));

    // reset in the middle of processing
    dc = done_cnt;
    @(negedge clk_25);
    start = 1'b1;
    bars_in = all_of(77);
    @(negedge clk_25);
    start = 1'b0;
    repeat (7) @(negedge clk_25);
    rst = 1'b1;
    @(negedge clk_25);
    rst = 1'b0;
    repeat (25) @(negedge clk_25);
    check("midrst_no_done", VW'(done_cnt - dc), VW'(0));
    check("midrst_bars", bars_out, '0);
    check("midrst_peaks", peaks_out, '0);
    run_frame(all_of(50));
    check("midrst_bar0", VW'(bar_of(bars_out, 0)), VW'(50));
    check("midrst_bar9", VW'(bar_of(bars_out, 9)), VW'(50));
    check("midrst_peak0", VW'(bar_of(peaks_out, 0)), VW'(50));

    // back-to-back frames: attack then decay
    run_frame(all_of(500));
    d1 = edge_cnt;
    check("b2b_bar0_a", VW'(bar_of(bars_out, 0)), VW'(500));
    run_frame(all_of(0));
    check("b2b_period", VW'(edge_cnt - d1), VW'(18));
    check("b2b_bar0_b", VW'(bar_of(bars_out, 0)), VW'(438));
    check("b2b_peak0_b", VW'(bar_of(peaks_out, 0)), VW'(500));

    repeat (3) @(negedge clk_25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
